// File: rtl/pipe_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and pipe_ctrl.
// The master drives stage information; the slave (pipe_ctrl) returns register controls.
interface pipe_ctrl_if #(parameter int CNT_W = 16);
    logic [7:0]       d_icode;
    logic [7:0]       d_srcA;
    logic [7:0]       d_srcB;
    logic [7:0]       e_icode;
    logic [7:0]       e_dstM;
    logic             e_cnd;
    logic [1:0]       m_stat;
    logic [1:0]       w_stat;
    logic             cnt_clr;
    logic             f_stall;
    logic             d_stall;
    logic             d_bubble;
    logic             e_bubble;
    logic             m_bubble;
    logic             w_stall;
    logic [1:0]       cpu_stat;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output d_icode, d_srcA, d_srcB, e_icode, e_dstM, e_cnd, m_stat, w_stat, cnt_clr,
        input  f_stall, d_stall, d_bubble, e_bubble, m_bubble, w_stall, cpu_stat, halted, stall_cnt
    );

    modport slave (
        input  d_icode, d_srcA, d_srcB, e_icode, e_dstM, e_cnd, m_stat, w_stat, cnt_clr,
        output f_stall, d_stall, d_bubble, e_bubble, m_bubble, w_stall, cpu_stat, halted, stall_cnt
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: load-use stalls, mispredict squash, RET fetch bubbles,
// exception drain and halt, plus a saturating fetch-stall performance counter.
module pipe_ctrl #(
    parameter int CNT_W = 16
) (
    input logic        clk,
    input logic        rst,
    pipe_ctrl_if.slave bus
);
    typedef enum logic [1:0] {RUN, RET_WAIT, DRAIN, HALTED} state_t;

    localparam logic [7:0] I_JXX    = 8'h07;
    localparam logic [7:0] I_RET    = 8'h09;
    localparam logic [7:0] I_MRMOVL = 8'h05;
    localparam logic [7:0] I_POPL   = 8'h0B;
    localparam logic [7:0] R_NONE   = 8'h0F;
    localparam logic [1:0] S_AOK    = 2'b00;

    state_t           state, state_nxt;
    logic [1:0]       ret_cnt, ret_cnt_nxt;
    logic [1:0]       cpu_stat;
    logic [CNT_W-1:0] stall_cnt;
    logic             load_use, mispred, halt_go;
    logic             f_stall, d_stall, d_bubble_req, e_bubble, m_bubble, w_stall;

    assign load_use = ((bus.e_icode == I_MRMOVL) || (bus.e_icode == I_POPL)) &&
                      (bus.e_dstM != R_NONE) &&
                      ((bus.e_dstM == bus.d_srcA) || (bus.e_dstM == bus.d_srcB));
    assign mispred  = (bus.e_icode == I_JXX) && !bus.e_cnd;

    always_comb begin
        state_nxt    = state;
        ret_cnt_nxt  = ret_cnt;
        halt_go      = 1'b0;
        f_stall      = 1'b0;
        d_stall      = 1'b0;
        d_bubble_req = 1'b0;
        e_bubble     = 1'b0;
        m_bubble     = 1'b0;
        w_stall      = 1'b0;
        case (state)
            RUN: begin
                if (bus.m_stat != S_AOK) begin
                    m_bubble  = 1'b1;
                    state_nxt = DRAIN;
                end else if (load_use) begin
                    f_stall  = 1'b1;
                    d_stall  = 1'b1;
                    e_bubble = 1'b1;
                end else if (mispred) begin
                    // A RET in decode is on the wrong path here, so it is squashed too.
                    d_bubble_req = 1'b1;
                    e_bubble     = 1'b1;
                end else if (bus.d_icode == I_RET) begin
                    f_stall      = 1'b1;
                    d_bubble_req = 1'b1;
                    state_nxt    = RET_WAIT;
                    ret_cnt_nxt  = 2'd1;
                end
            end
            RET_WAIT: begin
                if (bus.m_stat != S_AOK) begin
                    m_bubble  = 1'b1;
                    state_nxt = DRAIN;
                end else begin
                    f_stall      = 1'b1;
                    d_bubble_req = 1'b1;
                    if (ret_cnt != 2'd0) ret_cnt_nxt = ret_cnt - 2'd1;
                    else                 state_nxt   = RUN;
                end
            end
            DRAIN: begin
                f_stall      = 1'b1;
                d_bubble_req = 1'b1;
                e_bubble     = 1'b1;
                m_bubble     = 1'b1;
                if (bus.w_stat != S_AOK) begin
                    halt_go   = 1'b1;
                    state_nxt = HALTED;
                end
            end
            HALTED: begin
                f_stall  = 1'b1;
                d_stall  = 1'b1;
                e_bubble = 1'b1;
                m_bubble = 1'b1;
                w_stall  = 1'b1;
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            ret_cnt  <= 2'd0;
            cpu_stat <= S_AOK;
        end else begin
            state   <= state_nxt;
            ret_cnt <= ret_cnt_nxt;
            if (halt_go) cpu_stat <= bus.w_stat;
        end
    end

    // Counter saturates at all-ones; clear wins over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (bus.cnt_clr)
            stall_cnt <= '0;
        else if (f_stall && (state != HALTED) && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + 1'b1;
    end

    // Controls are forced low while reset is held; a stall beats a bubble in decode.
    assign bus.f_stall   = f_stall & ~rst;
    assign bus.d_stall   = d_stall & ~rst;
    assign bus.d_bubble  = d_bubble_req & ~d_stall & ~rst;
    assign bus.e_bubble  = e_bubble & ~rst;
    assign bus.m_bubble  = m_bubble & ~rst;
    assign bus.w_stall   = w_stall & ~rst;
    assign bus.halted    = (state == HALTED);
    assign bus.cpu_stat  = cpu_stat;
    assign bus.stall_cnt = stall_cnt;
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-high; ports named clk and rst.
REQ-002 Parameter CNT_W, default 16, width of stall performance counter.
REQ-003 Ports (name, direction, width, meaning):
- clk  in  1  pipeline clock
- rst  in  1  async active-high reset
- d_icode  in  8  icode in decode stage
- d_srcA  in  8  decode source reg A (0xF = none)
- d_srcB  in  8  decode source reg B (0xF = none)
- e_icode  in  8  icode in execute stage
- e_dstM  in  8  execute-stage load destination (0xF = none)
- e_cnd  in  1  branch condition computed in execute
- m_stat  in  2  memory-stage status: 00 AOK, 01 HLT, 10 ADR, 11 INS
- w_stat  in  2  writeback-stage status, same encoding
- cnt_clr  in  1  synchronous clear of stall_cnt
- f_stall, d_stall, d_bubble, e_bubble, m_bubble, w_stall  out  1 each  pipeline register controls
- cpu_stat  out  2  architectural status, registered
- halted  out  1  high in HALTED state
- stall_cnt  out  CNT_W  saturating count of fetch-stall cycles

Function
REQ-004 Icodes: HALT 0, JXX 7, RET 9, MRMOVL 5, POPL 0xB; all other values are non-hazard.
REQ-005 States: RUN, RET_WAIT, DRAIN, HALTED; 2-bit ret_cnt; control outputs are combinational from state and inputs.
REQ-006 load_use = (e_icode is MRMOVL or POPL) and e_dstM != 0xF and (e_dstM == d_srcA or e_dstM == d_srcB).
REQ-007 mispred = (e_icode == JXX) and !e_cnd.
REQ-008 RUN, load_use: f_stall=1, d_stall=1, e_bubble=1, d_bubble=0.
REQ-009 RUN, mispred and not load_use: d_bubble=1, e_bubble=1; lasts one cycle; no state change.
REQ-010 RUN, d_icode==RET, no load_use, no mispred: f_stall=1, d_bubble=1 that cycle; next state RET_WAIT, ret_cnt<=1.
REQ-011 RUN, d_icode==RET with load_use: apply REQ-008 only and stay in RUN; the RET is re-evaluated next cycle.
REQ-012 RUN, d_icode==RET with mispred: the RET is wrong-path; apply REQ-009 only and stay in RUN.
REQ-013 RET_WAIT: f_stall=1, d_bubble=1 every cycle.
- ret_cnt==1: ret_cnt<=0.
- ret_cnt==0: next state RUN.
- Fetch is therefore stalled exactly 3 consecutive cycles per RET.
REQ-014 In RUN or RET_WAIT, m_stat != AOK takes priority over REQ-008..013: next state DRAIN; m_bubble=1 in that same cycle.
REQ-015 DRAIN: f_stall=1, d_bubble=1, e_bubble=1, m_bubble=1; when w_stat != AOK, next state HALTED and cpu_stat<=w_stat.
REQ-016 HALTED: f_stall=1, d_stall=1, e_bubble=1, m_bubble=1, w_stall=1, halted=1; exits only on rst.
REQ-017 d_stall and d_bubble SHALL never both be 1; where both are requested, d_stall wins.
REQ-018 stall_cnt increments by 1 on each clock edge where f_stall==1 and state != HALTED; it saturates at all-ones with no wrap.
REQ-019 cnt_clr SHALL zero stall_cnt at the next edge and has priority over increment.

Reset
REQ-020 rst high SHALL immediately force:
- state RUN, ret_cnt 0, cpu_stat 00, halted 0, stall_cnt 0
- all stall/bubble outputs 0 while rst is asserted.
REQ-021 rst asserted mid-RET_WAIT or mid-DRAIN SHALL abandon the sequence; after release the block is in RUN with no residual stalls.

Verification
REQ-022 Load-use: e_icode=5, e_dstM=3, d_srcA=3 for 1 cycle -> f_stall=d_stall=e_bubble=1 that cycle only; stall_cnt 0->1.
REQ-023 RET: d_icode=9 in RUN, no hazards -> f_stall=d_bubble=1 for exactly 3 cycles, then 0; stall_cnt +3.
REQ-024 Mispredict plus RET: e_icode=7, e_cnd=0, d_icode=9 -> d_bubble=e_bubble=1, f_stall=0, state stays RUN.
REQ-025 Halt: m_stat=01 in RUN; w_stat=01 two cycles later -> DRAIN, then HALTED; cpu_stat=01, halted=1, w_stall=1 held until rst.
REQ-026 Saturation: preload near all-ones via continuous RET stalls with CNT_W=4 -> stall_cnt stops at 0xF; cnt_clr=1 -> 0 next edge.
REQ-027 Reset mid-RET_WAIT: assert rst asynchronously between edges -> outputs 0 immediately; after release, d_icode=1 -> no stalls.
